// File: rtl/divider_iter_pkg.sv
// rtl/divider_iter_pkg.sv - shared types, constants and helpers for the iterative divider
//
// Contents:
//   div_op_t     : decode divide-enable field {w, is, type_rem, unsgn}
//   div_state_t  : divider control states
//   DIV_ITER_D/W : iteration counts for 64-bit and 32-bit (W) operations
//   div_ext_w    : sign/zero extension of a 32-bit W operand to 64 bits
//   div_sext_w   : sign extension from bit 31, used for every W result
//   div_fixup    : sign correction of magnitude quotient/remainder and result
//                  selection; written generically so a multiplier can reuse it
package divider_iter_pkg;

  localparam int DIV_XLEN   = 64;
  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;

  // Bit order matches the decode divide-enable field: op[3]=w ... op[0]=unsgn.
  typedef struct packed {
    logic w;
    logic is;
    logic type_rem;
    logic unsgn;
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Extend a 32-bit W operand; sgn selects sign extension over zero extension.
  function automatic logic [63:0] div_ext_w(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

  function automatic logic [63:0] div_sext_w(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Magnitudes in, architectural result out. neg_q is (sign_a ^ sign_b),
  // neg_r is sign_a. W results are always sign-extended from bit 31, even
  // for the unsigned W variants.
  function automatic logic [63:0] div_fixup(input logic [63:0] quo,
                                            input logic [63:0] rem,
                                            input logic        neg_q,
                                            input logic        neg_r,
                                            input logic        type_rem,
                                            input logic        w);
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] sel;
    q   = neg_q ? (~quo + 64'd1) : quo;
    r   = neg_r ? (~rem + 64'd1) : rem;
    sel = type_rem ? r : q;
    return w ? div_sext_w(sel[31:0]) : sel;
  endfunction

endpackage

// File: rtl/divider_iter_step.sv
// rtl/divider_iter_step.sv - one radix-2 restoring division iteration (combinational)
//
// Ports:
//   rem_i  : partial remainder before the step
//   quo_i  : dividend/quotient shift register before the step; its MSB is the
//            next dividend bit brought into the remainder
//   dvs_i  : divisor magnitude
//   rem_o  : partial remainder after the step
//   quo_o  : shift register after the step, new quotient bit in the LSB
module divider_iter_step
  import divider_iter_pkg::*;
(
  input  logic [63:0] rem_i,
  input  logic [63:0] quo_i,
  input  logic [63:0] dvs_i,
  output logic [63:0] rem_o,
  output logic [63:0] quo_o
);

  logic [64:0] shifted;
  logic [64:0] diff;

  // The shifted remainder can reach 65 bits for unsigned divisors near 2^64,
  // so the trial subtraction is done at 65 bits. Because rem < divisor holds
  // before every step, a non-negative difference always fits back in 64 bits
  // and a negative one always shows up in bit 64.
  always_comb begin
    shifted = {rem_i, quo_i[63]};
    diff    = shifted - {1'b0, dvs_i};
    if (!diff[64]) begin
      rem_o = diff[63:0];
      quo_o = {quo_i[62:0], 1'b1};
    end else begin
      rem_o = shifted[63:0];
      quo_o = {quo_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - iterative radix-2 restoring divider for DIV/REM and their W forms
//
// Ports:
//   clk        : clock
//   resetn     : asynchronous active-low reset
//   flush      : abort any operation in flight (pipeline redirect)
//   in_valid   : request valid; must be held until in_ready
//   in_ready   : unit idle and not being flushed
//   op         : {w, is, type_rem, unsgn}; op[2] is not used
//   a, b       : dividend (rs1) and divisor (rs2)
//   out_valid  : result available, held until out_ready
//   out_ready  : consumer takes the result
//   result     : quotient or remainder; W results sign-extended from bit 31
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_t  state_q, state_d;
  div_op_t     op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] dvs_q, dvs_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;

  div_op_t     op_in;
  logic [63:0] a_ext, b_ext;
  logic        sa_in, sb_in;
  logic [63:0] mag_a, mag_b;
  logic        div_zero, ovf;
  logic [63:0] spec_raw;
  logic [63:0] step_rem, step_quo;
  logic        unused_is;

  assign op_in     = div_op_t'(op);
  assign unused_is = op_in.is;

  // Operand formation at accept time.
  always_comb begin
    a_ext    = op_in.w ? div_ext_w(a[31:0], ~op_in.unsgn) : a;
    b_ext    = op_in.w ? div_ext_w(b[31:0], ~op_in.unsgn) : b;
    sa_in    = ~op_in.unsgn & a_ext[63];
    sb_in    = ~op_in.unsgn & b_ext[63];
    mag_a    = sa_in ? (~a_ext + 64'd1) : a_ext;
    mag_b    = sb_in ? (~b_ext + 64'd1) : b_ext;
    div_zero = (b_ext == 64'd0);
    ovf      = ~op_in.unsgn & (b_ext == {64{1'b1}}) &
               (a_ext == (op_in.w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    // Architectural results for the two cases that bypass iteration.
    if (div_zero) begin
      spec_raw = op_in.type_rem ? a_ext : {64{1'b1}};
    end else begin
      spec_raw = op_in.type_rem ? 64'd0 : a_ext;
    end
  end

  divider_iter_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign in_ready  = (state_q == DIV_IDLE) & ~flush;
  assign out_valid = (state_q == DIV_DONE);
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (in_valid && in_ready) begin
          op_d  = op_in;
          sa_d  = sa_in;
          sb_d  = sb_in;
          dvs_d = mag_b;
          rem_d = 64'd0;
          // W dividends start in the upper half so the 32 shifts of a W
          // operation walk through exactly the 32 dividend bits.
          quo_d = op_in.w ? {mag_a[31:0], 32'd0} : mag_a;
          cnt_d = op_in.w ? 7'(DIV_ITER_W) : 7'(DIV_ITER_D);
          if (div_zero || ovf) begin
            result_d = op_in.w ? div_sext_w(spec_raw[31:0]) : spec_raw;
            state_d  = DIV_DONE;
          end else begin
            state_d  = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          result_d = div_fixup(step_quo, step_rem, sa_q ^ sb_q, sa_q,
                               op_q.type_rem, op_q.w);
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    // Flush overrides everything; a coincident out handshake has already
    // been seen by the consumer this cycle, so nothing extra is needed.
    if (flush) begin
      state_d = DIV_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_divider_iter.sv
// tb/tb_divider_iter.sv - scoreboard testbench for divider_iter
module tb_divider_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  divider_iter dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   first_seen = 0;
  bit   rdy_rand = 1;
  bit   rdy_force = 1;

  localparam logic [3:0] DIV   = 4'b0100, REM   = 4'b0110, DIVU  = 4'b0101, REMU  = 4'b0111;
  localparam logic [3:0] DIVW  = 4'b1100, REMW  = 4'b1110, DIVUW = 4'b1101, REMUW = 4'b1111;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: plain integer division with the RISC-V corner rules.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] av,
                                        input logic [63:0] bv, output int lat);
    logic        w, rm, un;
    logic [31:0] a32, b32, r32;
    int          sa32, sb32;
    longint      sa64, sb64;
    logic [63:0] r64;
    w = o[3]; rm = o[1]; un = o[0];
    if (w) begin
      a32 = av[31:0]; b32 = bv[31:0]; lat = 33;
      if (b32 == 0) begin
        r32 = rm ? a32 : 32'hFFFF_FFFF; lat = 1;
      end else if (!un && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        r32 = rm ? 32'd0 : a32; lat = 1;
      end else if (un) begin
        r32 = rm ? (a32 % b32) : (a32 / b32);
      end else begin
        sa32 = a32; sb32 = b32;
        r32 = rm ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      end
      return {{32{r32[31]}}, r32};
    end
    lat = 65;
    if (bv == 0) begin
      r64 = rm ? av : {64{1'b1}}; lat = 1;
    end else if (!un && av == 64'h8000_0000_0000_0000 && bv == {64{1'b1}}) begin
      r64 = rm ? 64'd0 : av; lat = 1;
    end else if (un) begin
      r64 = rm ? (av % bv) : (av / bv);
    end else begin
      sa64 = av; sb64 = bv;
      r64 = rm ? 64'(sa64 % sb64) : 64'(sa64 / sb64);
    end
    return r64;
  endfunction

  function automatic logic [63:0] rnd();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'($urandom_range(0, 20));
      1: v = -64'($urandom_range(1, 20));
      2: v = {$urandom, $urandom};
      3: v = 64'd0;
      4: v = {64{1'b1}};
      5: v = 64'h8000_0000_0000_0000;
      default: v = {{32{1'b0}}, ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : $urandom};
    endcase
    return v;
  endfunction

  // Call just after a rising edge; returns just after a rising edge.
  task automatic issue(input logic [3:0] o, input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] rv, input int lat, input bit push, output int t);
    int   n;
    exp_t e;
    op = o; a = av; b = bv; in_valid = 1'b1; n = 0; t = -1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got=in_ready_low exp=accept (cycle %0d)", cyc);
    end else begin
      t = cyc;
      if (push) begin
        e.res = rv; e.lat = lat; e.t = t;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] o, input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] rv, input int lat);
    int t;
    issue(o, av, bv, rv, lat, 1'b1, t);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
    end
    @(posedge clk); #1;
  endtask

  always begin
    @(posedge clk); #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid got=%h exp=no_output (cycle %0d)", result, cyc);
      end else begin
        if (!first_seen) begin
          chk("latency", 64'(cyc - q[0].t), 64'(q[0].lat));
          first_seen = 1;
        end
        chk("result", result, q[0].res);
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(q.pop_front());
          first_seen = 0;
        end
      end
    end
  end

  initial begin
    logic [3:0]  o;
    logic [63:0] av, bv, rv;
    int          lat, t, t2, n;

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    @(posedge clk); #1;

    // Directed operations.
    run(DIV,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run(REM,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run(4'b0001, 64'd100, 64'd7, 64'd14, 65);
    run(REMU,   64'd100, 64'd7, 64'd2, 65);
    run(DIVU,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run(DIV,    64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run(REM,    64'd5, 64'd0, 64'd5, 1);
    run(DIVW,   64'h0000_1234_0000_0005, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run(REMW,   64'h0000_1234_0000_0005, 64'd0, 64'd5, 1);
    run(REMUW,  64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1);
    run(DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run(REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run(DIVW,   64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run(DIVUW,  64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    run(DIVUW,  64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run(REMW,   -64'sd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    drain();

    // Hold out_ready low in DONE: result and in_ready must stay put.
    rdy_rand = 0; rdy_force = 0;
    @(posedge clk); #1;
    run(DIVU, 64'd1000, 64'd9, 64'd111, 65);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, 64'd111);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    rdy_force = 1;
    drain();

    // Flush in the same cycle as in_valid: no accept.
    op = DIV; a = 64'd5; b = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Flush at T+10; new request accepted at T+11.
    issue(DIVU, 64'd100, 64'd7, 64'd0, 65, 1'b0, t);
    while (cyc < t + 10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    issue(DIVU, 64'd77, 64'd10, 64'd7, 65, 1'b1, t2);
    chk("flush_reaccept_cycle", 64'(t2 - t), 64'd11);
    drain();

    // Reset pulsed mid-RUN.
    issue(DIV, -64'sd1000, 64'd3, 64'd0, 65, 1'b0, t);
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk); #1;
    run(REM, -64'sd1000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    drain();

    // Randomized operations against the reference model.
    rdy_rand = 1;
    for (int i = 0; i < 120; i++) begin
      o  = 4'($urandom);
      av = rnd();
      bv = rnd();
      rv = model(o, av, bv, lat);
      run(o, av, bv, rv, lat);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/divider_iter.md
Name: divider_iter

Overview:
- Iterative radix-2 restoring divider for the execute stage.
- Serves DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- Takes operands plus the 4-bit divide-enable field produced by decode.
- Execute stalls on the valid/ready handshakes until the result is returned.
- Results follow RISC-V semantics, including the divide-by-zero and overflow cases.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- flush  in  1  abort any operation in flight; pipeline redirect
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  4  {W, is, type_rem, unsgn}, same bit order as the decode divide-enable field; op[2] is ignored, requests are implied by in_valid
- a  in  64  dividend (rs1 value)
- b  in  64  divisor (rs2 value)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  64  quotient or remainder, 64-bit; W ops are sign-extended from bit 31

Behaviour:
- Reset (async on resetn low): state=IDLE; in_ready=1 after release; out_valid=0; result=0; all internal registers cleared.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) & ~flush.
- Accept when in_valid & in_ready, in cycle T. Latch op. Form operands:
  - W ops use a[31:0] and b[31:0]. Signed W ops sign-extend these; unsigned W ops zero-extend.
  - Latch dividend/divisor magnitudes and the two sign bits (signs are zero when unsgn=1).
  - Set iteration count N = 32 for W ops, 64 otherwise.
- Special cases are detected at accept and go directly to DONE at T+1:
  - Divisor==0: quotient = all ones of the op width; remainder = dividend.
  - Signed overflow (dividend = most-negative of the op width, divisor = -1): quotient = dividend; remainder = 0.
- Otherwise RUN occupies T+1..T+N, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor magnitude from rem using a 65-bit difference.
  - If non-negative, commit the subtraction and set quo LSB to 1.
  - Iteration counter is 7 bits and counts down. After the last iteration go to DONE at T+N+1.
- Entering DONE: apply sign fix-up and register result.
  - Quotient is negated if the signs differ.
  - Remainder is negated if the dividend sign is 1.
  - Select quotient or remainder by type_rem.
  - For W ops, sign-extend bit 31 to 64 bits; this applies to unsigned W ops too.
- DONE: out_valid=1 and result held stable until out_ready. The handshake cycle moves to IDLE; out_valid=0 next cycle.
- Back-to-back operation: a new request can be accepted in the cycle after the out handshake, not in the same cycle.
- flush:
  - From any state, go to IDLE next cycle and drop out_valid.
  - If flush coincides with out_valid & out_ready, the handshake still counts; the result is consumed.
  - If flush coincides with in_valid, no accept (flush wins).
- in_valid while busy is ignored; the requester must hold it.
- resetn low mid-RUN aborts immediately; there are no stale outputs after release.

Decomposition:
- Shared package additions:
  - typedef div_op_t, a packed struct {w, is, type_rem, unsgn} matching the decode divide-enable field.
  - enum div_state_t {DIV_IDLE, DIV_RUN, DIV_DONE}.
  - Constants DIV_ITER_D=64 and DIV_ITER_W=32.
  - Functions for W operand extension and the sign fix-up, reusable by a later multiplier.
- No sub-module is required. The single-iteration step (shift, trial subtract, select) can optionally be factored into a combinational div_step.

Test Plan:
- DIV a=-7, b=2 → result 0xFFFFFFFFFFFFFFFD (-3) with out_valid at T+65. REM on the same operands → 0xFFFFFFFFFFFFFFFF (-1).
- DIVU a=100, b=7 → 14. REMU → 2. DIVU a=0xFFFFFFFFFFFFFFFF, b=1 → 0xFFFFFFFFFFFFFFFF. All with 64-cycle RUN.
- Divide by zero:
  - DIV a=5, b=0 → 0xFFFFFFFFFFFFFFFF at T+1.
  - REM a=5, b=0 → 5.
  - DIVW a=0x123400000005, b=0 → 0xFFFFFFFFFFFFFFFF.
  - REMW on the same operands → 5.
- Overflow:
  - DIV a=0x8000000000000000, b=-1 → 0x8000000000000000; REM → 0.
  - DIVW a=0x0000000180000000, b=0xFFFFFFFF → 0xFFFFFFFF80000000 at T+1.
- W path:
  - DIVUW a=0x00000000FFFFFFFE, b=2 → 0x000000007FFFFFFF, out_valid at T+33.
  - REMW a=-9, b=4 → 0xFFFFFFFFFFFFFFFF.
- Control:
  - Flush at T+10 → IDLE at T+11, no out_valid, new request accepted at T+11.
  - Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0.
  - resetn pulsed low mid-RUN → out_valid=0 and in_ready=1 after release.
